seg_scan_mux: RTL and testbench

//  Parametrised time-multiplexed scanner for common-pin 7-segment display banks.

---
 rtl/seg_scan_mux.sv | 137 +++++++++++++
 tb/tb_seg_scan_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner: one digit lit per slot, PWM brightness,
// guard ticks at slot start, frame-synchronous shadowing of data/mask and
// selectable output polarity.
module seg_scan_mux #(
  parameter int unsigned N_DIGITS    = 6,
  parameter int unsigned SEG_W       = 8,
  parameter int unsigned BRIGHT_W    = 4,
  parameter int unsigned GUARD       = 1,
  parameter int unsigned COM_ACT_LOW = 0,
  parameter int unsigned SEG_ACT_LOW = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_DIGITS*SEG_W-1:0]     seg_array,
  input  logic [N_DIGITS-1:0]           blank_mask,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [SEG_W-1:0]              seg_data,
  output logic [N_DIGITS-1:0]           seg_com,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
  output logic                          frame_start
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [BRIGHT_W-1:0] PH_MAX   = '1;
  localparam logic [IDX_W-1:0]    DIG_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BRIGHT_W:0]   GUARD_X  = (BRIGHT_W + 1)'(GUARD);
  localparam logic [N_DIGITS-1:0] COM_OFF  = (COM_ACT_LOW != 0) ? '1 : '0;
  localparam logic [SEG_W-1:0]    SEG_OFF  = (SEG_ACT_LOW != 0) ? '1 : '0;

  logic [BRIGHT_W-1:0]       r_phase;
  logic [IDX_W-1:0]          r_digit;
  logic [N_DIGITS*SEG_W-1:0] r_shadow_arr;
  logic [N_DIGITS-1:0]       r_shadow_mask;
  logic [SEG_W-1:0]          r_seg_data;
  logic [N_DIGITS-1:0]       r_seg_com;
  logic                      r_frame_start;

  logic [BRIGHT_W-1:0]       w_phase_nxt;
  logic [IDX_W-1:0]          w_digit_nxt;
  logic                      w_frame_end;
  logic [N_DIGITS*SEG_W-1:0] w_arr_nxt;
  logic [N_DIGITS-1:0]       w_mask_nxt;
  logic [BRIGHT_W:0]         w_ph_x;
  logic                      w_lit;
  logic [N_DIGITS-1:0]       w_onehot;
  logic [SEG_W-1:0]          w_seg_sel;
  logic [N_DIGITS-1:0]       w_com_nxt;
  logic [SEG_W-1:0]          w_data_nxt;

  // Next scan position and frame-end shadow capture
  always_comb begin
    w_phase_nxt = r_phase;
    w_digit_nxt = r_digit;
    w_frame_end = 1'b0;
    w_arr_nxt   = r_shadow_arr;
    w_mask_nxt  = r_shadow_mask;
    if (en) begin
      w_phase_nxt = r_phase + 1'b1;
      if (r_phase == PH_MAX) begin
        if (r_digit == DIG_LAST) begin
          w_digit_nxt = '0;
          w_frame_end = 1'b1;
          w_arr_nxt   = seg_array;
          w_mask_nxt  = blank_mask;
        end else begin
          w_digit_nxt = r_digit + 1'b1;
        end
      end
    end
  end

  // Lit decision and pin values for the state after the edge; uses the
  // freshly captured shadow so a new frame shows new data from slot 0
  always_comb begin
    w_ph_x     = {1'b0, w_phase_nxt};
    w_lit      = (brightness != '0) && (w_ph_x >= GUARD_X) &&
                 ((w_ph_x - GUARD_X) < {1'b0, brightness}) &&
                 !w_mask_nxt[w_digit_nxt];
    w_onehot   = N_DIGITS'(1) << w_digit_nxt;
    w_seg_sel  = w_arr_nxt[w_digit_nxt * SEG_W +: SEG_W];
    w_com_nxt  = COM_OFF;
    w_data_nxt = SEG_OFF;
    if (w_lit) begin
      w_com_nxt  = w_onehot ^ COM_OFF;
      w_data_nxt = w_seg_sel ^ SEG_OFF;
    end
  end

  // Scan position registers advance only on scan ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_digit <= '0;
    end else if (en) begin
      r_phase <= w_phase_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  // Shadow copy of display data and blank mask, refreshed at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_arr  <= '0;
      r_shadow_mask <= '0;
    end else if (w_frame_end) begin
      r_shadow_arr  <= w_arr_nxt;
      r_shadow_mask <= w_mask_nxt;
    end
  end

  // Pin registers: segments and commons change together on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_com  <= COM_OFF;
      r_seg_data <= SEG_OFF;
    end else if (en) begin
      r_seg_com  <= w_com_nxt;
      r_seg_data <= w_data_nxt;
    end
  end

  // One-clock frame start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_end;
    end
  end

  assign seg_data    = r_seg_data;
  assign seg_com     = r_seg_com;
  assign digit_idx   = r_digit;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: a 6-digit active-high instance and a
// 4-digit active-low instance share clock, reset, scan tick and brightness.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [47:0] seg_array;
  logic [5:0]  blank_mask;
  logic [3:0]  brightness;
  logic [7:0]  seg_data;
  logic [5:0]  seg_com;
  logic [2:0]  digit_idx;
  logic        frame_start;

  logic [31:0] seg_array4;
  logic [3:0]  blank_mask4;
  logic [7:0]  l_seg_data;
  logic [3:0]  l_seg_com;
  logic [1:0]  l_digit_idx;
  logic        l_frame_start;

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  always #5 clk = ~clk;

  seg_scan_mux dut (
    .clk(clk), .rst(rst), .en(en), .seg_array(seg_array),
    .blank_mask(blank_mask), .brightness(brightness), .seg_data(seg_data),
    .seg_com(seg_com), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  seg_scan_mux #(.N_DIGITS(4), .COM_ACT_LOW(1), .SEG_ACT_LOW(1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .seg_array(seg_array4),
    .blank_mask(blank_mask4), .brightness(brightness), .seg_data(l_seg_data),
    .seg_com(l_seg_com), .digit_idx(l_digit_idx), .frame_start(l_frame_start)
  );

  typedef struct {
    int         tick;
    logic [3:0] br;
    logic [5:0] com;
    logic [7:0] data;
    logic [2:0] idx;
    logic       fs;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, t);
    end
  endtask

  // Apply scan ticks until the tick count reaches target, then stop ticking
  task automatic advance_to(input int target);
    while (t < target) begin
      en = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    en = 1'b0;
  endtask

  int dark;

  initial begin
    tbl[0]  = '{0,   4'd15, 6'h00, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1,   4'd15, 6'h01, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{95,  4'd15, 6'h20, 8'h00, 3'd5, 1'b0};
    tbl[3]  = '{96,  4'd15, 6'h00, 8'h00, 3'd0, 1'b1};
    tbl[4]  = '{97,  4'd15, 6'h01, 8'h10, 3'd0, 1'b0};
    tbl[5]  = '{112, 4'd15, 6'h00, 8'h00, 3'd1, 1'b0};
    tbl[6]  = '{113, 4'd15, 6'h02, 8'h11, 3'd1, 1'b0};
    tbl[7]  = '{127, 4'd15, 6'h02, 8'h11, 3'd1, 1'b0};
    tbl[8]  = '{145, 4'd15, 6'h08, 8'h13, 3'd3, 1'b0};
    tbl[9]  = '{192, 4'd15, 6'h00, 8'h00, 3'd0, 1'b1};
    tbl[10] = '{207, 4'd15, 6'h01, 8'h10, 3'd0, 1'b0};
    tbl[11] = '{208, 4'd3,  6'h00, 8'h00, 3'd1, 1'b0};
    tbl[12] = '{211, 4'd3,  6'h02, 8'h11, 3'd1, 1'b0};
    tbl[13] = '{212, 4'd3,  6'h00, 8'h00, 3'd1, 1'b0};
    tbl[14] = '{225, 4'd3,  6'h04, 8'h12, 3'd2, 1'b0};
    tbl[15] = '{226, 4'd0,  6'h00, 8'h00, 3'd2, 1'b0};

    rst = 1'b1;
    en = 1'b0;
    brightness = 4'd15;
    blank_mask = '0;
    blank_mask4 = '0;
    for (int k = 0; k < 6; k++) seg_array[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 4; k++) seg_array4[k*8 +: 8] = 8'h20 + 8'(k);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;

    // Full scan and dimming from the table
    for (int i = 0; i < 16; i++) begin
      brightness = tbl[i].br;
      advance_to(tbl[i].tick);
      chk("tbl_com",  32'(seg_com),     32'(tbl[i].com));
      chk("tbl_data", 32'(seg_data),    32'(tbl[i].data));
      chk("tbl_idx",  32'(digit_idx),   32'(tbl[i].idx));
      chk("tbl_fs",   32'(frame_start), 32'(tbl[i].fs));
    end

    // Brightness 0 keeps every common inactive for a whole frame
    dark = 0;
    for (int k = 0; k < 96; k++) begin
      advance_to(t + 1);
      if (seg_com != 6'h00) dark++;
    end
    chk("bright0_dark", 32'(dark), 32'd0);

    // Asynchronous reset mid-scan, both instances
    brightness = 4'd15;
    advance_to(t + 1);
    chk("prerst_com", 32'(seg_com), 32'h04);
    en = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_com",   32'(seg_com),     32'h00);
    chk("rst_data",  32'(seg_data),    32'h00);
    chk("rst_idx",   32'(digit_idx),   32'd0);
    chk("rst_fs",    32'(frame_start), 32'd0);
    chk("rst4_com",  32'(l_seg_com),   32'hF);
    chk("rst4_data", 32'(l_seg_data),  32'hFF);
    chk("rst4_idx",  32'(l_digit_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    t = 0;

    // First frame after reset, then the active-low 4-digit instance
    advance_to(96);
    chk("fs_96", 32'(frame_start), 32'd1);
    advance_to(97);
    chk("f1_com",    32'(seg_com),     32'h01);
    chk("f1_data",   32'(seg_data),    32'h10);
    chk("n4_com",    32'(l_seg_com),   32'hB);
    chk("n4_data",   32'(l_seg_data),  32'hDD);
    chk("n4_idx",    32'(l_digit_idx), 32'd2);
    advance_to(127);
    chk("n4_idx3",   32'(l_digit_idx), 32'd3);
    chk("n4_com3",   32'(l_seg_com),   32'h7);
    chk("n4_data3",  32'(l_seg_data),  32'hDC);
    advance_to(128);
    chk("n4_wrap",   32'(l_digit_idx), 32'd0);
    chk("n4_guard",  32'(l_seg_com),   32'hF);

    // Tear-free update: change data in the middle of slot 2
    advance_to(133);
    chk("tear_pre",  32'(seg_data), 32'h12);
    for (int k = 0; k < 6; k++) seg_array[k*8 +: 8] = 8'h40 + 8'(k);
    advance_to(134);
    chk("tear_s2",   32'(seg_data), 32'h12);
    advance_to(145);
    chk("tear_s3",   32'(seg_data), 32'h13);
    advance_to(191);
    chk("tear_s5",   32'(seg_data), 32'h15);
    chk("tear_idx5", 32'(digit_idx), 32'd5);
    advance_to(192);
    chk("tear_fs",   32'(frame_start), 32'd1);
    advance_to(193);
    chk("new_com",   32'(seg_com),  32'h01);
    chk("new_data",  32'(seg_data), 32'h40);

    // Blank mask on digit 2, visible only from the next frame
    blank_mask = 6'b000100;
    advance_to(225);
    chk("mask_late_com",  32'(seg_com),  32'h04);
    chk("mask_late_data", 32'(seg_data), 32'h42);
    advance_to(288);
    chk("mask_fs", 32'(frame_start), 32'd1);
    advance_to(305);
    chk("mask_d1_com",  32'(seg_com),  32'h02);
    chk("mask_d1_data", 32'(seg_data), 32'h41);
    dark = 0;
    for (int k = 0; k < 16; k++) begin
      advance_to(320 + k);
      if (seg_com != 6'h00 || seg_data != 8'h00) dark++;
    end
    chk("mask_d2_dark", 32'(dark), 32'd0);
    chk("mask_d2_idx",  32'(digit_idx), 32'd2);
    advance_to(337);
    chk("mask_d3_com",  32'(seg_com),  32'h08);
    chk("mask_d3_data", 32'(seg_data), 32'h43);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
